hog_line_buffer: RTL
====================

Name: hog_line_buffer

Overview:
- Upstream neighbour of the 3x3 window kernel in the HOG pipeline.
- Accepts a raster-order single-pixel stream (valid/ready) and holds BLOCK_HEIGHT-1 previous image lines.
- Emits one vertical column of BLOCK_HEIGHT pixels per accepted input pixel, in the packed form the kernel consumes on its in_pixels/in_valid/in_ready ports.

Parameters:
- DATA_WIDTH, 8: bits per pixel.
- BLOCK_HEIGHT, 3: rows per output column; must be at least 2.
- IMG_WIDTH, 640: pixels per line; must be at least 2.
- IMG_HEIGHT, 480: lines per frame; must be at least BLOCK_HEIGHT.

Ports:
- clk, input, 1: single clock; all logic on its rising edge.
- rst, input, 1: asynchronous, active-high reset.
- in_pixel, input, DATA_WIDTH: raster pixel.
- in_valid, input, 1: in_pixel is valid.
- in_ready, output, 1: block can accept in_pixel.
- out_pixels, output, DATA_WIDTH*BLOCK_HEIGHT: column. Slice i is bits [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i]. i=0 is the oldest (top) line; i=BLOCK_HEIGHT-1 is the current line.
- out_valid, output, BLOCK_HEIGHT: per-row valid. All bits are always equal (replicated).
- out_ready, input, BLOCK_HEIGHT: per-row ready from the kernel. A column transfers only when out_valid and all out_ready bits are 1 (out_fire).

Behaviour:
- Reset (async, rst=1):
  - state=FILL; col=0; row=0; out_valid=0; out_pixels=0.
  - in_ready=0 while rst is high.
  - Line memory contents are don't-care.
- Input transfer: in_fire = in_valid & in_ready.
- Storage: BLOCK_HEIGHT-1 lines of IMG_WIDTH entries (line[0] oldest).
  - On every in_fire at column col: line[k][col] <= line[k+1][col] for k < BLOCK_HEIGHT-2, and line[BLOCK_HEIGHT-2][col] <= in_pixel.
- Counters: col increments on in_fire and wraps IMG_WIDTH-1 -> 0. row increments on each col wrap.
- FILL state:
  - in_ready=1; no output is produced.
  - When in_fire occurs at col=IMG_WIDTH-1 and row=BLOCK_HEIGHT-2: go to STREAM with row=BLOCK_HEIGHT-1.
- STREAM state:
  - in_ready = !out_valid[0] | out_fire, so back-to-back transfers run at 1 pixel/clock.
  - On in_fire: out_pixels <= {in_pixel, line[BLOCK_HEIGHT-2][col], ..., line[0][col]} (slice 0 = line[0]), read before that column's shift. out_valid <= all ones.
  - On out_fire without in_fire: out_valid <= 0.
- Latency: one clock from in_fire to the corresponding column on out_pixels.
- Output stability: out_pixels and out_valid hold while out_valid=1 and out_fire=0.
  - A partial out_ready (some bits 0) is a stall, not a transfer.
- End of frame: in_fire at col=IMG_WIDTH-1 and row=IMG_HEIGHT-1 -> state=FILL, row=0, col=0.
  - The last column is still emitted and drains normally.
  - The next frame refills lines; no columns spanning frames are emitted.
- Reset mid-frame: all counters and state return immediately to the reset values; a pending output column is dropped.
- Output count: (IMG_HEIGHT-BLOCK_HEIGHT+1)*IMG_WIDTH columns per frame.

Optional Feature:
- Macro: HOG_LINE_BUFFER_MARKERS_EN.
- When defined, adds two outputs:
  - out_eol, 1 bit: high with the column taken from col=IMG_WIDTH-1.
  - out_eof, 1 bit: high with the column taken from col=IMG_WIDTH-1, row=IMG_HEIGHT-1.
- Both markers are registered alongside out_pixels, reset to 0, and held under stall.
- When undefined, the ports and their logic are absent; all other behaviour is identical.

Test Plan:
1. Frame fill. Params: DATA_WIDTH=8, BLOCK_HEIGHT=3, IMG_WIDTH=4, IMG_HEIGHT=4. Pixel = row*16+col, in_valid=1 continuously, out_ready=3'b111.
   - No out_valid during the first 8 pixels.
   - Row 2 produces out_pixels 24'h201000, 24'h211101, 24'h221202, 24'h231303.
   - Row 3 produces 24'h302010 ... 24'h332313.
   - Total 8 columns.
2. Backpressure. As test 1, but hold out_ready=3'b110 for 3 cycles while out_valid=1.
   - out_pixels is unchanged and in_ready=0 during those cycles.
   - After restoring 3'b111, the stream resumes with no lost or duplicated columns.
3. Input bubbles. Toggle in_valid every other cycle.
   - Output sequence is identical to test 1.
   - out_valid is deasserted between columns when no in_fire occurs.
4. Two frames back-to-back.
   - The second frame again emits nothing for its first 8 pixels.
   - Its first column is 24'h201000 (same pattern); no column mixes frames.
5. Reset mid-frame. Assert rst asynchronously after 10 pixels.
   - out_valid=0 and in_ready=0 immediately.
   - After release, a full frame reproduces test 1 exactly.
6. Markers, with HOG_LINE_BUFFER_MARKERS_EN defined.
   - out_eol is high on columns 24'h231303 and 24'h332313.
   - out_eof is high only on 24'h332313.

Source files
------------

// File: rtl/hog_line_buffer.sv
// Line buffer feeding the HOG 3x3 window kernel: stores BLOCK_HEIGHT-1 lines and emits one
// vertical column per accepted pixel. Define HOG_LINE_BUFFER_MARKERS_EN for out_eol/out_eof.
module hog_line_buffer #(
  parameter int DATA_WIDTH   = 8,
  parameter int BLOCK_HEIGHT = 3,
  parameter int IMG_WIDTH    = 640,
  parameter int IMG_HEIGHT   = 480
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_WIDTH-1:0]          in_pixel,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [DATA_WIDTH*BLOCK_HEIGHT-1:0] out_pixels,
  output logic [BLOCK_HEIGHT-1:0]        out_valid,
  input  logic [BLOCK_HEIGHT-1:0]        out_ready
`ifdef HOG_LINE_BUFFER_MARKERS_EN
  ,
  output logic                           out_eol,
  output logic                           out_eof
`endif
);

  localparam int LINES = BLOCK_HEIGHT - 1;
  localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  typedef enum logic {
    S_FILL,
    S_STREAM
  } state_t;

  state_t                            state_q, state_d;
  logic [COL_W-1:0]                  col_q, col_d;
  logic [ROW_W-1:0]                  row_q, row_d;
  logic                              out_valid_q, out_valid_d;
  logic [DATA_WIDTH*BLOCK_HEIGHT-1:0] out_pixels_q, out_pixels_d;
`ifdef HOG_LINE_BUFFER_MARKERS_EN
  logic                              eol_q, eol_d;
  logic                              eof_q, eof_d;
`endif

  logic [DATA_WIDTH-1:0] line_q [LINES][IMG_WIDTH];

  logic out_fire;
  logic in_fire;
  logic col_last;
  logic row_fill_last;
  logic row_frame_last;

  always_comb begin
    out_fire       = out_valid_q & (&out_ready);
    in_ready       = !rst & ((state_q == S_FILL) | !out_valid_q | out_fire);
    in_fire        = in_valid & in_ready;
    col_last       = (col_q == COL_W'(IMG_WIDTH - 1));
    row_fill_last  = (row_q == ROW_W'(BLOCK_HEIGHT - 2));
    row_frame_last = (row_q == ROW_W'(IMG_HEIGHT - 1));
  end

  // Column assembly reads the stored lines before this pixel's shift lands
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    out_valid_d  = out_valid_q;
    out_pixels_d = out_pixels_q;
`ifdef HOG_LINE_BUFFER_MARKERS_EN
    eol_d        = eol_q;
    eof_d        = eof_q;
`endif

    if (in_fire) begin
      col_d = col_last ? '0 : col_q + COL_W'(1);
    end

    case (state_q)
      S_FILL: begin
        if (in_fire && col_last) begin
          row_d = row_q + ROW_W'(1);
          if (row_fill_last) begin
            state_d = S_STREAM;
          end
        end
      end
      S_STREAM: begin
        if (in_fire) begin
          for (int k = 0; k < LINES; k++) begin
            out_pixels_d[DATA_WIDTH*k +: DATA_WIDTH] = line_q[k][col_q];
          end
          out_pixels_d[DATA_WIDTH*LINES +: DATA_WIDTH] = in_pixel;
`ifdef HOG_LINE_BUFFER_MARKERS_EN
          eol_d = col_last;
          eof_d = col_last & row_frame_last;
`endif
          if (col_last) begin
            if (row_frame_last) begin
              state_d = S_FILL;
              row_d   = '0;
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end
        end
      end
      default: begin
        state_d = S_FILL;
      end
    endcase

    // The last column of a frame still drains after the state has returned to FILL
    if (in_fire && (state_q == S_STREAM)) begin
      out_valid_d = 1'b1;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_FILL;
      col_q        <= '0;
      row_q        <= '0;
      out_valid_q  <= 1'b0;
      out_pixels_q <= '0;
`ifdef HOG_LINE_BUFFER_MARKERS_EN
      eol_q        <= 1'b0;
      eof_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      out_valid_q  <= out_valid_d;
      out_pixels_q <= out_pixels_d;
`ifdef HOG_LINE_BUFFER_MARKERS_EN
      eol_q        <= eol_d;
      eof_q        <= eof_d;
`endif
    end
  end

  // Line storage: each accepted pixel pushes its column up by one line
  always_ff @(posedge clk) begin
    if (in_fire) begin
      for (int k = 0; k < LINES - 1; k++) begin
        line_q[k][col_q] <= line_q[k+1][col_q];
      end
      line_q[LINES-1][col_q] <= in_pixel;
    end
  end

  assign out_pixels = out_pixels_q;
  assign out_valid  = {BLOCK_HEIGHT{out_valid_q}};
`ifdef HOG_LINE_BUFFER_MARKERS_EN
  assign out_eol    = eol_q;
  assign out_eof    = eof_q;
`endif

endmodule
